cpu_trace_uart: RTL and testbench

- Downstream observer of the CPU datapath. Consumes its `pc_out` (8-bit PC) and `dbg_reg_out` (R3 mirror).
- Captures a trace record each time the watched value changes. Buffers records in a FIFO.
- Streams each record off-chip as a 4-byte 8N1 UART frame, for board-level debug without a logic analyser.

---
 rtl/cpu_trace_uart_if.sv | 25 ++
 rtl/cpu_trace_uart.sv | 170 +++++++++++++++++
 tb/tb_cpu_trace_uart.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_uart_if.sv
// Trace-capture bundle between the CPU datapath observer and its UART side:
// CPU step/value inputs plus the serial line and FIFO status outputs.
interface cpu_trace_uart_if #(
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             en;
   logic [7:0]       pc_in;
   logic [15:0]      reg_in;
   logic             tx;
   logic             busy;
   logic             overflow;
   logic [CNT_W-1:0] fifo_count;

   modport master (
      output en, pc_in, reg_in,
      input  tx, busy, overflow, fifo_count
   );

   modport slave (
      input  en, pc_in, reg_in,
      output tx, busy, overflow, fifo_count
   );
endinterface

// File: rtl/cpu_trace_uart.sv
// Captures {pc, R3} whenever R3 changes (or PC too, with CPU_TRACE_PC_EN defined), buffers
// the records in a FIFO and streams each as a 4-byte 8N1 UART frame: sync, pc, reg hi, reg lo.
module cpu_trace_uart #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input logic             clk,
   input logic             reset,
   cpu_trace_uart_if.slave bus
);
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

   state_t             state_q;
   logic [23:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [15:0]        last_reg_q;
   logic               overflow_q;
   logic               tx_q;
   logic               busy_q;
   logic [23:0]        rec_q;
   logic [BAUD_W-1:0]  baud_q;
   logic [2:0]         bit_idx_q;
   logic [1:0]         byte_idx_q;

   logic               capture;
   logic               full;
   logic               push_ok;
   logic               pop;
   logic [7:0]         cur_byte;

`ifdef CPU_TRACE_PC_EN
   logic [7:0] last_pc_q;

   assign capture = bus.en && ((bus.reg_in != last_reg_q) || (bus.pc_in != last_pc_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_pc_q <= 8'h00;
      end else if (bus.en) begin
         last_pc_q <= bus.pc_in;
      end
   end
`else
   assign capture = bus.en && (bus.reg_in != last_reg_q);
`endif

   // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
   assign full    = (count_q == FULL_COUNT);
   assign push_ok = capture && !full;
   assign pop     = (state_q == StIdle) && (count_q != '0);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= {bus.pc_in, bus.reg_in};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_reg_q <= 16'h0000;
         overflow_q <= 1'b0;
      end else begin
         if (capture) begin
            last_reg_q <= bus.reg_in;
         end
         if (capture && full) begin
            overflow_q <= 1'b1;
         end
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
      end
   end

   always_comb begin
      cur_byte = SYNC_BYTE;
      unique case (byte_idx_q)
         2'd0: cur_byte = SYNC_BYTE;
         2'd1: cur_byte = rec_q[23:16];
         2'd2: cur_byte = rec_q[15:8];
         2'd3: cur_byte = rec_q[7:0];
         default: cur_byte = SYNC_BYTE;
      endcase
   end

   // tx and busy are registered from the current state, so the line trails the FSM by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         rec_q      <= '0;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
      end else begin
         busy_q <= (state_q != StIdle) || (count_q != '0);
         unique case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (pop) begin
                  rec_q      <= mem[rd_ptr_q];
                  byte_idx_q <= '0;
                  baud_q     <= '0;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               tx_q <= 1'b0;
               if (baud_q == BAUD_LAST) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  state_q   <= StData;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            StData: begin
               tx_q <= cur_byte[bit_idx_q];
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= StStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            StStop: begin
               tx_q <= 1'b1;
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (byte_idx_q == 2'd3) begin
                     state_q <= StIdle;
                  end else begin
                     byte_idx_q <= byte_idx_q + 2'd1;
                     state_q    <= StStart;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.overflow   = overflow_q;
   assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_cpu_trace_uart.sv
// Bench for cpu_trace_uart: queue-based trace model plus a UART line decoder.
module tb_cpu_trace_uart;
   localparam int unsigned CPB       = 4;
   localparam int unsigned DEPTH     = 4;
   localparam int          FRAME_CYC = 40 * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [7:0]  pc = 8'h00;
   logic [15:0] rg = 16'h0000;

   int vectors = 0;
   int miscompares = 0;

   cpu_trace_uart_if #(.FIFO_DEPTH(DEPTH)) bus ();

   assign bus.en     = en;
   assign bus.pc_in  = pc;
   assign bus.reg_in = rg;

   cpu_trace_uart #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: record queue, cycles left on the frame in flight, expected frames.
   logic [23:0] m_q[$];
   logic [23:0] exp_frames[$];
   logic [31:0] rx_q[$];
   int          m_rem;
   logic        m_over;
   logic        m_busy;
   logic [15:0] m_last_reg;
   logic [7:0]  m_last_pc;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_frames.delete();
      rx_q.delete();
      m_rem      = 0;
      m_over     = 1'b0;
      m_busy     = 1'b0;
      m_last_reg = 16'h0000;
      m_last_pc  = 8'h00;
   endtask

   task automatic model_edge();
      bit full;
      bit pop;
      bit cap;
      full   = (m_q.size() == DEPTH);
      pop    = (m_rem == 0) && (m_q.size() != 0);
      m_busy = (m_rem != 0) || (m_q.size() != 0);
`ifdef CPU_TRACE_PC_EN
      cap = en && ((rg != m_last_reg) || (pc != m_last_pc));
      if (en) m_last_pc = pc;
`else
      cap = en && (rg != m_last_reg);
`endif
      if (cap) m_last_reg = rg;
      if (pop) begin
         exp_frames.push_back(m_q.pop_front());
         m_rem = FRAME_CYC;
      end else if (m_rem > 0) begin
         m_rem--;
      end
      if (cap) begin
         if (full) m_over = 1'b1;
         else m_q.push_back({pc, rg});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("fifo_count", 32'(bus.fifo_count), m_q.size());
      chk("overflow", 32'(bus.overflow), 32'(m_over));
      chk("busy", 32'(bus.busy), 32'(m_busy));
   endtask

   task automatic drain();
      int n = 0;
      while ((m_rem != 0 || m_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(n < 3000), 1);
      repeat (4) tick();
   endtask

   task automatic cmp_frames(input string name);
      chk({name, "_frames"}, rx_q.size(), exp_frames.size());
      while (rx_q.size() != 0 && exp_frames.size() != 0) begin
         chk(name, rx_q.pop_front(), {8'hA5, exp_frames.pop_front()});
      end
      rx_q.delete();
      exp_frames.delete();
   endtask

   // Line decoder: frame cycle c counts from the first low cycle, mid-bit sampling.
   initial begin
      int          mpos;
      int          c;
      int          k;
      int          b;
      logic        merr;
      logic [31:0] mshift;
      mpos   = 0;
      merr   = 1'b0;
      mshift = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mpos = 0;
         end else if (mpos == 0) begin
            if (bus.tx == 1'b0) begin
               mpos   = 1;
               merr   = 1'b0;
               mshift = '0;
            end
         end else begin
            mpos++;
         end
         if (mpos != 0) begin
            c = mpos - 1;
            k = c / CPB;
            b = k % 10;
            if (c == FRAME_CYC) begin
               chk("frame_err", 32'(merr), 0);
               chk("frame_idle", 32'(bus.tx), 1);
               rx_q.push_back(mshift);
               mpos = 0;
            end else begin
               if (c % CPB == 0 && b == 0) merr = merr | (bus.tx != 1'b0);
               if (c % CPB == CPB / 2) begin
                  if (b == 0) merr = merr | (bus.tx != 1'b0);
                  else if (b == 9) merr = merr | (bus.tx != 1'b1);
                  else mshift[8 * (3 - k / 10) + (b - 1)] = bus.tx;
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(bus.tx), 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_count", 32'(bus.fifo_count), 0);
      reset = 1'b0;

      // Steady value: nothing captured.
      en = 1'b1;
      repeat (50) begin
         tick();
         chk("t1_tx", 32'(bus.tx), 1);
      end
      chk("t1_frames", rx_q.size(), 0);

      // Single change, start bit two edges after capture.
      pc = 8'h05;
      rg = 16'h1234;
      tick();
      chk("t2_tx_e0", 32'(bus.tx), 1);
      tick();
      chk("t2_tx_e1", 32'(bus.tx), 1);
      tick();
      chk("t2_tx_e2", 32'(bus.tx), 0);
      drain();
      chk("t2_count", rx_q.size(), 1);
      cmp_frames("t2");

      // Six back-to-back changes: one in flight, four buffered, one dropped.
      for (int i = 0; i < 6; i++) begin
         pc = 8'h10 + 8'(i);
         rg = 16'h1000 + 16'(i) * 16'h0111;
         tick();
      end
      chk("t3_full", 32'(bus.fifo_count), DEPTH);
      chk("t3_over", 32'(bus.overflow), 1);
      drain();
      chk("t3_over_sticky", 32'(bus.overflow), 1);
      chk("t3_count", rx_q.size(), 5);
      cmp_frames("t3");

      // Reset while shifting data bit 1 of the reg-hi byte.
      pc = 8'h33;
      rg = 16'h0055;
      tick();
      for (int n = 1; n <= 92; n++) begin
         if (n == 10) rg = 16'h0066;
         if (n == 11) rg = 16'h0077;
         tick();
      end
      chk("t4_tx_pre", 32'(bus.tx), 0);
      #2 reset = 1'b1;
      #1;
      chk("t4_tx_async", 32'(bus.tx), 1);
      chk("t4_count", 32'(bus.fifo_count), 0);
      chk("t4_over", 32'(bus.overflow), 0);
      chk("t4_busy", 32'(bus.busy), 0);
      rg = 16'h0000;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (200) tick();
      chk("t4_quiet", rx_q.size(), 0);
      cmp_frames("t4");

      // en low blocks capture; raising it captures the pending difference once.
      en = 1'b0;
      pc = 8'h00;
      for (int i = 0; i < 20; i++) begin
         rg = (i % 2 == 0) ? 16'h0001 : 16'h0002;
         tick();
      end
      chk("t5_none", 32'(bus.fifo_count) + rx_q.size(), 0);
      rg = 16'h0002;
      en = 1'b1;
      tick();
      drain();
      chk("t5_count", rx_q.size(), 1);
      cmp_frames("t5");

      // PC stepping with constant reg.
      pc = 8'h01;
      tick();
      pc = 8'h02;
      tick();
      drain();
`ifdef CPU_TRACE_PC_EN
      chk("t6_count", rx_q.size(), 2);
`else
      chk("t6_count", rx_q.size(), 0);
`endif
      cmp_frames("t6");

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 3) != 0);
         rg = 16'($urandom_range(0, 3));
         pc = 8'($urandom);
         tick();
      end
      drain();
      cmp_frames("rand");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
